// File: rtl/sorter_ctrl.sv
// Packet sequencer for one sorter instance: load a packet from the sink stream,
// wait for the sort, unload the sorted words to the source stream, then clear the sorter.
module sorter_ctrl #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_sop_i,
    input  logic              snk_eop_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_sop_o,
    output logic              src_eop_o,
    output logic              src_valid_o,
    output logic              srt_wren_o,
    output logic              srt_sort_op_o,
    output logic              srt_output_op_o,
    output logic              srt_clear_op_o,
    output logic [AWIDTH-1:0] srt_cntr_o,
    output logic [DWIDTH-1:0] srt_data_o,
    input  logic [DWIDTH-1:0] srt_data_i,
    input  logic              srt_done_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int CW = AWIDTH + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << AWIDTH) - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DROP, SORT, UNLOAD, CLEAR} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] ocnt;
    logic [WW-1:0] wdog;
    logic          beat;

    // DROP keeps accepting so the tail of a truncated packet can be flushed through eop.
    assign snk_ready_o = (state == IDLE) || (state == LOAD) || (state == DROP);
    assign beat        = snk_valid_i & snk_ready_o;
    assign busy_o      = (state != IDLE);
    assign srt_wren_o  = srt_sort_op_o;
    assign src_data_o  = src_valid_o ? srt_data_i : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state           <= IDLE;
            cnt             <= '0;
            ocnt            <= '0;
            wdog            <= '0;
            srt_sort_op_o   <= 1'b0;
            srt_output_op_o <= 1'b0;
            srt_clear_op_o  <= 1'b0;
            srt_cntr_o      <= '1;
            srt_data_o      <= '0;
            src_valid_o     <= 1'b0;
            src_sop_o       <= 1'b0;
            src_eop_o       <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            srt_sort_op_o  <= 1'b0;
            srt_clear_op_o <= 1'b0;
            err_o          <= 1'b0;
            // Sorter read data lands one cycle after output_op; flags travel with it.
            src_valid_o    <= srt_output_op_o;
            src_sop_o      <= srt_output_op_o && (ocnt == CW'(1));
            src_eop_o      <= srt_output_op_o && (ocnt == cnt);

            case (state)
                IDLE: begin
                    if (beat && snk_sop_i) begin
                        srt_sort_op_o <= 1'b1;
                        srt_data_o    <= snk_data_i;
                        cnt           <= CW'(1);
                        if (snk_eop_i) begin
                            srt_cntr_o <= '0;
                            state      <= SORT;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        srt_sort_op_o <= 1'b1;
                        srt_data_o    <= snk_data_i;
                        cnt           <= cnt + 1'b1;
                        if (snk_eop_i) begin
                            srt_cntr_o <= cnt[AWIDTH-1:0];
                            state      <= SORT;
                        end else if (cnt == LAST_IDX) begin
                            srt_cntr_o <= cnt[AWIDTH-1:0];
                            err_o      <= 1'b1;
                            state      <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (beat && snk_eop_i) begin
                        state <= SORT;
                    end
                end
                SORT: begin
                    if (srt_done_i) begin
                        srt_output_op_o <= 1'b1;
                        ocnt            <= CW'(1);
                        wdog            <= '0;
                        state           <= UNLOAD;
                    end else if (wdog == WD_LIMIT) begin
                        err_o          <= 1'b1;
                        srt_clear_op_o <= 1'b1;
                        wdog           <= '0;
                        state          <= CLEAR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (ocnt == cnt) begin
                        srt_output_op_o <= 1'b0;
                        srt_clear_op_o  <= 1'b1;
                        state           <= CLEAR;
                    end else begin
                        ocnt <= ocnt + 1'b1;
                    end
                end
                CLEAR: begin
                    cnt        <= '0;
                    ocnt       <= '0;
                    srt_cntr_o <= '1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
